// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_unit_pkg;

  typedef logic [31:0] Inst;
  typedef logic [31:0] InstAddr;

  typedef struct packed {
    InstAddr pc;
    Inst     inst;
  } FetchEntry;

  typedef enum logic {
    ST_RUN,
    ST_REDIRECT_PENDING
  } fetch_state_t;

  localparam InstAddr RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int      QUEUE_DEPTH      = 2;

  // Redirect targets are word addresses; the two low bits carry no meaning.
  function automatic InstAddr word_align(input InstAddr a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - two-entry {pc, inst} queue between ICache and decode
module fetch_queue
  import fetch_unit_pkg::*;
(
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_push,
  input  FetchEntry  i_entry,
  input  logic       i_pop,
  input  logic       i_flush,
  output FetchEntry  o_head,
  output logic [1:0] o_count
);

  FetchEntry  r_mem [QUEUE_DEPTH];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       w_do_push;
  logic       w_do_pop;

  assign w_do_push = i_push && (r_count != 2'd2);
  assign w_do_pop  = i_pop  && (r_count != 2'd0);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      for (int i = 0; i < QUEUE_DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_entry;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC sequencing, ICache request control and redirect handling
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter InstAddr RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic [31:0] o_cache_addr,
  output logic        o_cache_rd,
  input  logic [31:0] i_cache_inst,
  input  logic        i_cache_busy,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  input  logic        i_ready
);

  fetch_state_t r_state;
  InstAddr      r_pc;
  InstAddr      r_target;
  logic         r_outstanding;

  FetchEntry    w_head;
  FetchEntry    w_entry;
  logic [1:0]   w_count;
  logic         w_rd;
  logic         w_accept;
  logic         w_valid;
  logic         w_push;
  logic         w_pop;
  InstAddr      w_redirect_pc;

  assign w_redirect_pc = word_align(i_redirect_pc);

  // Once a request is in flight it stays asserted until the cache answers.
  always_comb begin
    w_rd = 1'b0;
    if (!i_reset)
      w_rd = (r_state == ST_REDIRECT_PENDING) || (w_count < 2'd2) || r_outstanding;
  end

  assign w_accept = w_rd && !i_cache_busy;
  assign w_valid  = !i_reset && (w_count != 2'd0);
  assign w_push   = (r_state == ST_RUN) && w_accept && !i_redirect;
  assign w_pop    = w_valid && i_ready && !i_redirect;
  assign w_entry  = '{pc: r_pc, inst: i_cache_inst};

  fetch_queue u_queue (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_entry (w_entry),
    .i_pop   (w_pop),
    .i_flush (i_redirect),
    .o_head  (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= ST_RUN;
      r_pc          <= RESET_PC;
      r_target      <= '0;
      r_outstanding <= 1'b0;
    end else begin
      r_outstanding <= w_rd && i_cache_busy;
      case (r_state)
        ST_RUN: begin
          if (i_redirect) begin
            if (i_cache_busy) begin
              r_target <= w_redirect_pc;
              r_state  <= ST_REDIRECT_PENDING;
            end else begin
              r_pc <= w_redirect_pc;
            end
          end else if (w_accept) begin
            r_pc <= r_pc + 32'd4;
          end
        end
        // The stale refill must complete before the new target can be requested.
        ST_REDIRECT_PENDING: begin
          if (i_redirect && i_cache_busy) begin
            r_target <= w_redirect_pc;
          end else if (i_redirect) begin
            r_pc    <= w_redirect_pc;
            r_state <= ST_RUN;
          end else if (!i_cache_busy) begin
            r_pc    <= r_target;
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign o_cache_addr = i_reset ? RESET_PC : r_pc;
  assign o_cache_rd   = w_rd;
  assign o_valid      = w_valid;
  assign o_inst       = w_valid ? w_head.inst : '0;
  assign o_pc         = w_valid ? w_head.pc   : '0;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the fetch address loaded on reset.
REQ-002 SHALL have port i_clock  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port i_reset  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port o_cache_addr  out  32  byte address of instruction requested from ICache (equals PC).
REQ-005 SHALL have port o_cache_rd  out  1  read request to ICache.
REQ-006 SHALL have port i_cache_inst  in  32  instruction from ICache, valid when o_cache_rd=1 and i_cache_busy=0.
REQ-007 SHALL have port i_cache_busy  in  1  ICache refill in progress; request not accepted this cycle.
REQ-008 SHALL have port i_redirect  in  1  one-cycle pulse: branch/jump, discard fetched stream.
REQ-009 SHALL have port i_redirect_pc  in  32  new fetch address, sampled when i_redirect=1.
REQ-010 SHALL have port o_valid  out  1  queue head holds an instruction for decode.
REQ-011 SHALL have port o_inst  out  32  queue head instruction.
REQ-012 SHALL have port o_pc  out  32  address of o_inst.
REQ-013 SHALL have port i_ready  in  1  decode consumes head when o_valid=1 and i_ready=1 (pop).

Function
REQ-014 SHALL keep a 2-entry FIFO of {pc, inst}, count 0..2; o_valid = (count != 0); o_inst/o_pc driven from head.
REQ-015 SHALL have FSM states RUN and REDIRECT_PENDING.
REQ-016 In RUN, o_cache_rd SHALL be 1 when count < 2, or when a request is outstanding (i_cache_busy=1 last cycle with rd=1).
REQ-017 Accept: o_cache_rd=1 and i_cache_busy=0 at edge -> push {PC, i_cache_inst}, PC <= PC+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0).
REQ-018 While i_cache_busy=1, o_cache_addr and o_cache_rd SHALL stay unchanged; rd never drops mid-refill.
REQ-019 Latency: ICache hit -> instruction visible on o_valid the cycle after accept; back-to-back hits with i_ready=1 give one instruction per cycle.
REQ-020 Push and pop in the same cycle SHALL leave count unchanged; push when count=2 is impossible by REQ-016.
REQ-021 Redirect in RUN with i_cache_busy=0: FIFO flushed (count=0), any same-cycle cache result discarded, PC <= i_redirect_pc, remain RUN.
REQ-022 Redirect with i_cache_busy=1 (RUN or REDIRECT_PENDING): FIFO flushed, target latched (later redirect overwrites), state -> REDIRECT_PENDING, address held.
REQ-023 In REDIRECT_PENDING: o_valid=0, rd held; when i_cache_busy=0, returned instruction discarded, PC <= latched target, state -> RUN.
REQ-024 Redirect has priority over push and pop in the same cycle; a pop coincident with redirect is still considered consumed by decode.
REQ-025 i_redirect_pc bits [1:0] SHALL be ignored (forced 0).

Reset
REQ-026 On i_reset=1 at edge: PC <= RESET_PC, count <= 0, state <= RUN, pending target <= 0.
REQ-027 During and after reset cycle: o_valid=0, o_cache_rd=0 in reset cycle, o_cache_addr=RESET_PC, o_inst/o_pc=0.
REQ-028 Reset mid-refill SHALL abandon the request; ICache is reset by the same i_reset.

Structure
REQ-029 Types package SHALL hold Inst (32-bit), InstAddr and a FetchEntry struct {pc, inst}; RESET_PC default lives there as a constant.
REQ-030 FIFO SHALL be a separate sub-module fetch_queue (depth 2, push/pop/flush, count); FSM and PC in fetch_unit.

Verification
REQ-031 Reset, ICache always hit, i_ready=1 -> o_pc sequence 0,4,8,C one per cycle from cycle 2, o_inst matches ROM.
REQ-032 Miss: busy high 5 cycles at PC=0x10 -> o_cache_addr held 0x10, rd held 1, o_valid drops after FIFO drains, resumes with 0x10.
REQ-033 i_ready=0 for 4 cycles -> count saturates at 2, rd=0, no instruction lost or duplicated after i_ready=1.
REQ-034 Redirect to 0x100 on a hit cycle -> next o_pc=0x100, no stale PC ever presented.
REQ-035 Redirect to 0x200 then 0x300 during a 6-cycle miss -> stalled result discarded, first o_pc=0x300.
REQ-036 PC=0xFFFF_FFFC accepted -> next o_cache_addr=0x0000_0000; i_reset mid-miss -> o_cache_addr=RESET_PC, o_valid=0.
